calc_bcd_conv: RTL

- Sequential binary-to-BCD converter downstream of the 3-bit calculator arithmetic stage.
- Accepts an unsigned magnitude plus sign flag and converts it by shift-and-add-3 (double dabble), one bit per clock.
- Presents packed BCD digits to the display/decoder stage over a valid/ready handshake.
- Sized by default for a 3-bit x 3-bit product (max 49) or any 6-bit result.

---
 rtl/calc_bcd_conv.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/calc_bcd_conv.sv
// calc_bcd_conv: sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Accepts an unsigned magnitude plus sign over valid/ready and returns packed BCD digits.
// The result passes through a registered output stage before out_valid rises.
// Optional macro CALC_BCD_BLANK_EN adds out_blank (leading-zero blanking flags).
module calc_bcd_conv #(
  parameter int unsigned IN_W   = 6,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_neg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_neg
`ifdef CALC_BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     out_blank
`endif
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(IN_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   bin_q, bin_d;
  logic [BcdW-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              out_valid_q, out_valid_d;
  logic [BcdW-1:0]   out_bcd_q, out_bcd_d;
  logic              out_neg_q, out_neg_d;

  // Digit correction: add 3 to every digit >= 5 ahead of the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i+:4] >= 4'd5) bcd_adj[4*i+:4] = bcd_q[4*i+:4] + 4'd3;
    end
  end

`ifdef CALC_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d, blank_calc;
  logic              all_zero;

  // Bit i set when digit i and every higher digit are zero; the units digit never blanks.
  always_comb begin
    blank_calc = '0;
    all_zero   = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      all_zero      = all_zero & (bcd_q[4*i+:4] == 4'd0);
      blank_calc[i] = all_zero;
    end
  end
`endif

  // Next-state logic for the FSM, datapath and output stage.
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;
    out_bcd_d   = out_bcd_q;
    out_neg_d   = out_neg_q;
`ifdef CALC_BCD_BLANK_EN
    blank_d     = blank_q;
`endif
    in_ready    = (state_q == StIdle);
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          bin_d   = in_data;
          bcd_d   = '0;
          neg_d   = in_neg;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CntW'(IN_W - 1)) state_d = StDone;
      end
      StDone: begin
        if (!out_valid_q) begin
          // First DONE cycle loads the output registers; they then hold until handshake.
          out_valid_d = 1'b1;
          out_bcd_d   = bcd_q;
          out_neg_d   = neg_q;
`ifdef CALC_BCD_BLANK_EN
          blank_d     = blank_calc;
`endif
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any partial conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
      out_neg_q   <= 1'b0;
`ifdef CALC_BCD_BLANK_EN
      blank_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
      out_bcd_q   <= out_bcd_d;
      out_neg_q   <= out_neg_d;
`ifdef CALC_BCD_BLANK_EN
      blank_q     <= blank_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;
  assign out_neg   = out_neg_q;
`ifdef CALC_BCD_BLANK_EN
  assign out_blank = blank_q;
`endif

endmodule
